muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation encodings as presented on the op input.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // LO value written by any divide whose divisor is zero.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: i_acc = {partial product, remaining multiplier bits}; one shift-add step.
// Divide:   i_acc = {partial remainder, remaining dividend bits}; one restoring step.
// For divide, o_acc[0] is left zero and the new quotient bit is returned on o_qbit.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic                 o_qbit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem;

  // Compute both step variants and select by operation class.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
    w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_operand});
    w_rem   = w_shift[WIDTH-1:0];
    o_acc   = i_acc;
    o_qbit  = 1'b0;

    if (i_acc[0]) begin
      w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    end else begin
      w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
    end

    // The true difference is below the divisor, so a WIDTH-bit subtract is exact.
    if (w_ge) begin
      w_rem = w_shift[WIDTH-1:0] - i_operand;
    end else begin
      w_rem = w_shift[WIDTH-1:0];
    end

    if (i_is_div) begin
      o_acc  = {w_rem, i_acc[WIDTH-2:0], 1'b0};
      o_qbit = w_ge;
    end else begin
      o_acc  = {w_sum, i_acc[WIDTH-1:1]};
      o_qbit = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on operand magnitudes for ITER cycles, then applies signs and writes HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_signed;
  logic             w_op_div;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [DW-1:0]    w_acc_nxt;
  logic             w_qbit;
  logic [DW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Decode the incoming op and form operand magnitudes (raw for unsigned ops).
  always_comb begin
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_op_div = (op == OP_DIV) || (op == OP_DIVU);
    if (w_signed && a[WIDTH-1]) begin
      w_a_mag = ~a + WIDTH'(1);
    end else begin
      w_a_mag = a;
    end
    if (w_signed && b[WIDTH-1]) begin
      w_b_mag = ~b + WIDTH'(1);
    end else begin
      w_b_mag = b;
    end
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_is_div  (r_is_div),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .o_acc     (w_acc_nxt),
    .o_qbit    (w_qbit)
  );

  // Sign fix-up of the finished magnitude result.
  always_comb begin
    w_prod_fix = r_acc;
    w_quo_fix  = r_acc[WIDTH-1:0];
    w_rem_fix  = r_acc[DW-1:WIDTH];
    if (r_neg_q) begin
      w_prod_fix = ~r_acc + DW'(1);
      w_quo_fix  = ~r_acc[WIDTH-1:0] + WIDTH'(1);
    end else begin
      w_prod_fix = r_acc;
      w_quo_fix  = r_acc[WIDTH-1:0];
    end
    if (r_neg_r) begin
      w_rem_fix = ~r_acc[DW-1:WIDTH] + WIDTH'(1);
    end else begin
      w_rem_fix = r_acc[DW-1:WIDTH];
    end
  end

  // Sequencer, iteration counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Multiplier sits in the low half; dividend sits in the low half.
            if (w_op_div) begin
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd <= w_b_mag;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
              r_opnd <= w_a_mag;
            end
            r_is_div <= w_op_div;
            r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_signed && a[WIDTH-1];
            r_div0   <= w_op_div && (b == '0);
            r_cnt    <= '0;
            r_state  <= ST_CALC;
          end else begin
            if (mthi) begin
              r_hi <= wdata;
            end
            if (mtlo) begin
              r_lo <= wdata;
            end
          end
        end
        ST_CALC: begin
          r_acc <= {w_acc_nxt[DW-1:1], w_acc_nxt[0] | w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            if (r_div0) begin
              r_lo <= WIDTH'(DIV0_LO);
            end else begin
              r_lo <= w_quo_fix;
            end
          end else begin
            r_hi <= w_prod_fix[DW-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random checks of muldiv_unit with a scoreboard of expected {HI,LO}.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: native SV arithmetic with MIPS divide-by-zero convention.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned uq;
    longint unsigned ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    model = 64'd0;
    case (o)
      2'b00: model = sx * sy;
      2'b01: model = ux * uy;
      2'b10: begin
        if (y == 32'd0) begin
          model = {x, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
      2'b11: begin
        if (y == 32'd0) begin
          model = {x, 32'hFFFF_FFFF};
        end else begin
          uq = ux / uy;
          ur = ux % uy;
          model = {ur[31:0], uq[31:0]};
        end
      end
      default: model = 64'd0;
    endcase
  endfunction

  // Launch one operation, watch busy/done, compare against the scoreboard.
  // chain=1 returns in the done cycle so the caller can start back-to-back.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp,
                       input bit with_mtlo, input bit poke, input bit chain);
    logic [63:0] old;
    logic [63:0] e;
    int busy_cnt;
    bit seen;
    sb_q.push_back(exp);
    old   = {hi, lo};
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    mtlo  = with_mtlo;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    mtlo  = 1'b0;
    a     = $urandom;
    b     = $urandom;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (i == 5 || i == 20) check({tag, "_hold"}, {hi, lo}, old);
        if (poke && i == 5) begin
          start = 1'b1; op = 2'b01; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_0BAD;
        end
        if (poke && i == 6) begin
          start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    e = sb_q.pop_front();
    if (seen) begin
      check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
      check({tag, "_result"}, {hi, lo}, e);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      if (!chain) begin
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    logic [1:0]  ro;
    bit saw_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MTHI alone, then MTHI+MTLO together.
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi", {hi, lo}, 64'h0000_1234_0000_0000);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

    // Directed arithmetic cases.
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 1'b0);
    do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 1'b0);
    do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
    do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0);
    do_op("divu_0",    2'b11, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    do_op("div_0_neg", 2'b10, 32'hFFFF_FF9C, 32'd0,         64'hFFFF_FF9C_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    do_op("divu_b2b",  2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0, 1'b0, 1'b0);
    do_op("start_mtlo",2'b01, 32'd3,         32'd4,         64'h0000_0000_0000_000C, 1'b1, 1'b0, 1'b0);
    do_op("mult_poke", 2'b00, 32'd7,         32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 1'b1, 1'b0);

    // Random operations checked against the reference model.
    for (int k = 0; k < 8; k++) begin
      rx = $urandom;
      ry = (k == 3) ? 32'd0 : (((k & 1) != 0) ? ($urandom & 32'h0000_FFFF) : $urandom);
      ro = 2'(k);
      do_op("rand", ro, rx, ry, model(ro, rx, ry), 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a divide aborts it.
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no_done_after_rst", {63'd0, saw_done}, 64'd0);
    check("hilo_after_rst", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
